// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: valid/ready on both sides,
// flush, result hold under back-pressure, tag passthrough.
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [TAG_W-1:0] tag;
  } req_t;

  // op 2 (MULHU) is the only zero-extended multiply
  function automatic logic [XLEN-1:0] mul_res(input logic [2:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic              sx;
    logic [2*XLEN-1:0] ea, eb, p;
    sx = (op != 3'd2);
    ea = {{XLEN{sx & a[XLEN-1]}}, a};
    eb = {{XLEN{sx & b[XLEN-1]}}, b};
    p  = ea * eb;
    return (op == 3'd1 || op == 3'd2) ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic sgn, input logic [XLEN-1:0] x);
    return (sgn & x[XLEN-1]) ? -x : x;
  endfunction

  state_t           state, state_d;
  req_t             req_q;
  logic [XLEN-1:0]  rem_q, rem_nx, quo_q, quo_nx, dvs_q;
  logic [XLEN:0]    shifted, trial;
  logic             ge, neg_q, neg_r;
  logic [CW-1:0]    cnt;
  logic             accept, in_sgn, in_div0, in_ovf, in_special, done_entry;
  logic [XLEN-1:0]  spec_res, div_res, res_d;

  assign in_ready   = (state == S_IDLE) & ~flush;
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);

  assign in_sgn     = in_op[2] & ~in_op[0];
  assign in_div0    = (in_src2 == '0);
  assign in_ovf     = in_sgn & (in_src1 == XMIN) & (in_src2 == '1);
  assign in_special = in_op[2] & (in_div0 | in_ovf);
  assign spec_res   = in_div0 ? (in_op[1] ? in_src1 : '1) : (in_op[1] ? '0 : XMIN);

  // restoring step: quo_q holds the remaining dividend bits, quotient bits shift in at the LSB
  assign shifted = {1'b0, rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign ge      = ~trial[XLEN];
  assign rem_nx  = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], ge};
  assign div_res = req_q.op[1] ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) begin
        if (!in_op[2])       state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
        else if (in_special) state_d = S_DONE;
        else                 state_d = S_DIV;
      end
      S_MUL:  if (cnt == CW'(MUL_LAT - 1)) state_d = S_DONE;
      S_DIV:  if (cnt == CW'(XLEN - 1))    state_d = S_DONE;
      S_DONE: if (out_ready)               state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    res_d = out_result;
    case (state)
      S_IDLE:  res_d = in_op[2] ? spec_res : mul_res(in_op, in_src1, in_src2);
      S_MUL:   res_d = mul_res(req_q.op, req_q.src1, req_q.src2);
      S_DIV:   res_d = div_res;
      default: res_d = out_result;
    endcase
  end

  assign done_entry = (state != S_DONE) && (state_d == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt        <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (accept) begin
        req_q <= '{op: in_op, src1: in_src1, src2: in_src2, tag: in_tag};
        cnt   <= in_op[2] ? '0 : CW'(1);
        rem_q <= '0;
        quo_q <= mag(in_sgn, in_src1);
        dvs_q <= mag(in_sgn, in_src2);
        neg_q <= in_sgn & ~in_op[1] & (in_src1[XLEN-1] ^ in_src2[XLEN-1]);
        neg_r <= in_sgn &  in_op[1] & in_src1[XLEN-1];
      end else if (state == S_MUL || state == S_DIV) begin
        cnt <= cnt + CW'(1);
      end
      if (state == S_DIV) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
      end
      if (done_entry) begin
        out_result <= res_d;
        out_tag    <= (state == S_IDLE) ? in_tag : req_q.tag;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors with literal expectations plus a
// cycle-level arithmetic model checked on every cycle.
module tb_muldiv_unit;
  localparam int XLEN = 32, MUL_LAT = 2, TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_src1, in_src2, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_chk = 0, n_fail = 0;
  int n_acc = 0, n_out = 0, n_kill = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint     sa, sb, t;
    logic [63:0] up, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    v  = 64'(sa * sb);
    case (op)
      3'd1: return v[63:32];
      3'd2: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        t = sa / sb; v = 64'(t); return v[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        t = sa % sb; v = 64'(t); return v[31:0];
      end
      3'd7: return (b == 0) ? a : a % b;
      default: return v[31:0];
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return XLEN + 1;
  endfunction

  // model: at most one op outstanding, countdown to result, then hold until taken
  logic        m_pend = 1'b0;
  int          m_rem  = 0;
  logic [31:0] m_res;
  logic [4:0]  m_tag;
  logic        e_vld, e_rdy;

  always @(negedge clk) begin
    if (reset) begin
      m_pend = 1'b0;
    end else begin
      e_vld = m_pend && (m_rem == 0);
      e_rdy = !m_pend && !flush;
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("out_valid", 32'(out_valid), 32'(e_vld));
      chk("busy", 32'(busy), 32'(m_pend));
      if (e_vld) begin
        chk("out_result", out_result, m_res);
        chk("out_tag", 32'(out_tag), 32'(m_tag));
      end
      if (e_vld && out_ready) begin
        n_out++;
        m_pend = 1'b0;
      end else if (flush) begin
        if (m_pend) n_kill++;
        m_pend = 1'b0;
      end else if (m_pend && m_rem > 0) begin
        m_rem--;
      end
      if (flush) m_pend = 1'b0;
      if (in_valid && e_rdy) begin
        m_pend = 1'b1;
        m_rem  = ref_lat(in_op, in_src1, in_src2) - 1;
        m_res  = ref_res(in_op, in_src1, in_src2);
        m_tag  = in_tag;
        n_acc++;
      end
    end
  end

  // called at posedge+1 with the unit idle; returns at posedge+1 after the handshake
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int lat,
                        input string nm);
    int c;
    c = 0;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    do begin @(negedge clk); c++; end while (!out_valid && c < 200);
    chk({nm, " latency"}, 32'(c), 32'(lat));
    chk(nm, out_result, exp);
    chk({nm, " tag"}, 32'(out_tag), 32'(tag));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_tag", 32'(out_tag), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, MUL_LAT, "MUL");
    run_op(3'd1, 32'h7, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFF, MUL_LAT, "MULH");
    run_op(3'd2, 32'h7, 32'hFFFF_FFFD, 5'd3, 32'h0000_0006, MUL_LAT, "MULHU");
    run_op(3'd3, 32'h7, 32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB, MUL_LAT, "MUL rsvd");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, "DIV -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, "MOD -7/2");
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC, 33, "DIVU");
    run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'hFFFF_FFF2, 33, "DIV 100/-7");
    run_op(3'd6, 32'd100, 32'hFFFF_FFF9, 5'd10, 32'd2, 33, "MOD 100/-7");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1, "MOD ovf");
    run_op(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, "DIVU by 0");
    run_op(3'd7, 32'd5, 32'd0, 5'd14, 32'd5, 1, "MODU by 0");
    run_op(3'd4, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, 1, "DIV by 0");

    // back-pressure: result must hold for 10 cycles
    in_valid = 1'b1; in_op = 3'd5; in_src1 = 32'hFFFF_FFF9; in_src2 = 32'd2; in_tag = 5'd3;
    out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!out_valid && c < 200);
    chk("hold latency", 32'(c), 32'd33);
    repeat (10) begin
      @(negedge clk);
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold out_result", out_result, 32'h7FFF_FFFC);
      chk("hold out_tag", 32'(out_tag), 32'd3);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release in_ready", 32'(in_ready), 32'd1);
    chk("release out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // flush at iteration 10 of a divide
    in_valid = 1'b1; in_op = 3'd4; in_src1 = 32'd1000; in_src2 = 32'd7; in_tag = 5'd4;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("flushed out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4, 5'd9, 32'd12, MUL_LAT, "MUL after flush");

    // random traffic; the model does all checking
    for (int i = 0; i < 4000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 3'($urandom_range(0, 7));
      in_src1   = pick();
      in_src2   = pick();
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("accepted = delivered + killed", 32'(n_acc), 32'(n_out + n_kill));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
